// File: rtl/approx_div_pkg.sv
// Shared types for the approximate restoring divider.
package approx_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/maskable_borrow_subtractor.sv
// Ripple-borrow subtractor where a set mask bit makes that lane drop its borrow
// (difference is a plain XOR and nothing propagates upward).
module maskable_borrow_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] mask,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] w_borrow;

    always_comb begin
        diff     = '0;
        w_borrow = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                diff[i]       = a[i] ^ b[i];
                w_borrow[i+1] = 1'b0;
            end else begin
                diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
                w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
            end
        end
        bout = w_borrow[N];
    end

endmodule

// File: rtl/approx_restoring_divider.sv
// Iterative restoring divider (one quotient bit per cycle) on a maskable-borrow subtractor.
// Optional DIV_MISMATCH_FLAG_EN adds an exact shadow subtractor and a sticky approx_mismatch flag.
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready high
//  RUN   | one restoring iteration per cycle, WIDTH cycles
//  DONE  | result held on outputs until out_ready
module approx_restoring_divider
    import approx_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`ifdef DIV_MISMATCH_FLAG_EN
    ,
    output logic             approx_mismatch
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_dvd_sh;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic             r_dbz;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_rshift;
    logic [WIDTH:0]   w_diff;
    logic             w_bout;
    logic             w_unused;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    // Dividend is consumed MSB first by shifting the latched copy left each iteration.
    assign w_rshift = {r_rem, r_dvd_sh[WIDTH-1]};
    assign w_unused = w_diff[WIDTH];

    maskable_borrow_subtractor #(.N(WIDTH + 1)) u_msub (
        .a    (w_rshift),
        .b    ({1'b0, r_divisor}),
        .mask ({1'b0, r_mask}),
        .diff (w_diff),
        .bout (w_bout)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_next = (divisor == '0) ? DONE : RUN;
            RUN:  if (w_last) w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dvd_sh  <= '0;
            r_divisor <= '0;
            r_mask    <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_dbz     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_dvd_sh  <= dividend;
                r_divisor <= divisor;
                r_mask    <= mask;
                r_cnt     <= '0;
                if (divisor == '0) begin
                    r_quot <= '1;
                    r_rem  <= dividend;
                    r_dbz  <= 1'b1;
                end else begin
                    r_quot <= '0;
                    r_rem  <= '0;
                    r_dbz  <= 1'b0;
                end
            end else if (r_state == RUN) begin
                r_cnt    <= r_cnt + 1'b1;
                r_dvd_sh <= {r_dvd_sh[WIDTH-2:0], 1'b0};
                r_quot   <= {r_quot[WIDTH-2:0], ~w_bout};
                r_rem    <= w_bout ? w_rshift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

`ifdef DIV_MISMATCH_FLAG_EN
    logic [WIDTH:0] w_ex_diff;
    logic           w_ex_bout;
    logic           r_mismatch;

    maskable_borrow_subtractor #(.N(WIDTH + 1)) u_exact_sub (
        .a    (w_rshift),
        .b    ({1'b0, r_divisor}),
        .mask ('0),
        .diff (w_ex_diff),
        .bout (w_ex_bout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_mismatch <= 1'b0;
        end else if (r_state == RUN) begin
            if ((w_diff != w_ex_diff) || (w_bout != w_ex_bout))
                r_mismatch <= 1'b1;
        end
    end

    assign approx_mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_approx_restoring_divider.sv
// Randomized and directed bench for approx_restoring_divider against an arithmetic reference model.
module tb_approx_restoring_divider;

    localparam int W = 8;
    localparam int LAT_RUN = W;   // edges from accept edge until out_valid is seen
    localparam int LAT_DBZ = 0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend, divisor, mask;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero;
    logic         mm_obs;
`ifdef DIV_MISMATCH_FLAG_EN
    logic         approx_mismatch;
    assign mm_obs = approx_mismatch;
`else
    assign mm_obs = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    approx_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .mask        (mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`ifdef DIV_MISMATCH_FLAG_EN
        ,
        .approx_mismatch (approx_mismatch)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Approximate subtraction on 9 lanes: masked lanes are XOR, each run of
    // unmasked lanes subtracts as an independent integer with no borrow in.
    function automatic void approx_sub(input int a, input int b, input int m,
                                       output int d, output bit bo);
        int i, j, fld, s;
        d = 0; bo = 0; i = 0;
        while (i < W + 1) begin
            if (((m >> i) & 1) == 1) begin
                d |= (((a ^ b) >> i) & 1) << i;
                bo = 0;
                i++;
            end else begin
                j = i;
                while (j < W + 1 && ((m >> j) & 1) == 0) j++;
                fld = (1 << (j - i)) - 1;
                s = ((a >> i) & fld) - ((b >> i) & fld);
                d |= (s & fld) << i;
                bo = (s < 0);
                i = j;
            end
        end
    endfunction

    function automatic void model(input int dvd, input int dvs, input int msk,
                                  output logic [W-1:0] q, output logic [W-1:0] rm,
                                  output logic dz, output logic mm);
        int r, rp, d, ed, qi;
        bit bo, eb;
        mm = 0;
        if (dvs == 0) begin
            q = '1; rm = W'(dvd); dz = 1; return;
        end
        dz = 0; r = 0; qi = 0;
        for (int k = W - 1; k >= 0; k--) begin
            rp = ((r & 255) << 1) | ((dvd >> k) & 1);
            approx_sub(rp, dvs, msk & 255, d, bo);
            ed = (rp - dvs) & 511;
            eb = (rp < dvs);
            if (d != ed || bo != eb) mm = 1;
            qi = qi * 2 + (bo ? 0 : 1);
            r = bo ? rp : d;
        end
        q = W'(qi);
        rm = W'(r & 255);
    endfunction

    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic [W-1:0] msk,
                          output logic [W-1:0] q, output logic [W-1:0] rm,
                          output logic dz, output logic mm, output int lat, output int acc_cyc);
        dividend = dvd; divisor = dvs; mask = msk; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient; rm = remainder; dz = div_by_zero; mm = mm_obs;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        dividend = 8'd99; divisor = 8'd3; mask = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, mm_obs} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b vld=%b q=%0d r=%0d dz=%b mm=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, mm_obs);
        end
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                            input logic [W-1:0] msk, input logic [W-1:0] want_q, input logic [W-1:0] want_r,
                            input logic want_dz, input logic want_mm, input int want_lat);
        logic [W-1:0] q, rm;
        logic dz, mm;
        int lat, ac;
        run_op(dvd, dvs, msk, q, rm, dz, mm, lat, ac);
        n_cmp++;
        if (q !== want_q || rm !== want_r || dz !== want_dz) begin
            n_fail++;
            $display("FAIL %s: %0d/%0d m=%h got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                     name, dvd, dvs, msk, q, rm, dz, want_q, want_r, want_dz);
        end
        n_cmp++;
        if (lat !== want_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges, want %0d", name, lat, want_lat);
        end
`ifdef DIV_MISMATCH_FLAG_EN
        n_cmp++;
        if (mm !== want_mm) begin
            n_fail++;
            $display("FAIL %s_mismatch: got %b, want %b", name, mm, want_mm);
        end
`endif
    endtask

    task automatic test_directed();
        check_op("exact_200_7", 8'd200, 8'd7, 8'h00, 8'd28, 8'd4, 1'b0, 1'b0, LAT_RUN);
        check_op("benign_7_2", 8'd7, 8'd2, 8'h01, 8'd3, 8'd1, 1'b0, 1'b0, LAT_RUN);
        check_op("approx_13_3", 8'd13, 8'd3, 8'h03, 8'd255, 8'd12, 1'b0, 1'b1, LAT_RUN);
        check_op("exact_255_1", 8'd255, 8'd1, 8'h00, 8'd255, 8'd0, 1'b0, 1'b0, LAT_RUN);
        check_op("exact_5_255", 8'd5, 8'd255, 8'h00, 8'd0, 8'd5, 1'b0, 1'b0, LAT_RUN);
    endtask

    task automatic test_div_by_zero();
        check_op("dbz_55_0", 8'd55, 8'd0, 8'h00, 8'd255, 8'd55, 1'b1, 1'b0, LAT_DBZ);
        // div_by_zero must clear on the next accept
        check_op("after_dbz", 8'd100, 8'd10, 8'h00, 8'd10, 8'd0, 1'b0, 1'b0, LAT_RUN);
    endtask

    task automatic test_random();
        logic [W-1:0] dvd, dvs, msk, wq, wr;
        logic wdz, wmm;
        int sel;
        for (int n = 0; n < 40; n++) begin
            dvd = W'($urandom_range(0, 255));
            dvs = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            sel = $urandom_range(0, 2);
            msk = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : W'($urandom_range(0, 255));
            model(int'(dvd), int'(dvs), int'(msk), wq, wr, wdz, wmm);
            check_op("random", dvd, dvs, msk, wq, wr, wdz, wmm, (dvs == 0) ? LAT_DBZ : LAT_RUN);
        end
    endtask

    task automatic test_all_ones_mask();
        logic [W-1:0] dvd, dvs, wq, wr;
        logic wdz, wmm;
        for (int n = 0; n < 4; n++) begin
            dvd = W'($urandom_range(0, 255));
            dvs = W'($urandom_range(1, 255));
            model(int'(dvd), int'(dvs), 255, wq, wr, wdz, wmm);
            check_op("mask_ff", dvd, dvs, 8'hFF, 8'hFF, wr, 1'b0, wmm, LAT_RUN);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hq, hr;
        logic hdz;
        int lat;
        dividend = 8'd200; divisor = 8'd7; mask = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        hq = quotient; hr = remainder; hdz = div_by_zero;
        n_cmp++;
        if (out_valid !== 1'b1 || hq !== 8'd28 || hr !== 8'd4) begin
            n_fail++;
            $display("FAIL bp_result: vld=%b q=%0d r=%0d, want 1 28 4", out_valid, hq, hr);
        end
        dividend = 8'd9; divisor = 8'd2; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 8'd28 ||
                remainder !== 8'd4 || div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cyc %0d vld=%b rdy=%b q=%0d r=%0d dz=%b, want 1 0 28 4 0",
                         c, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ignored_req: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        dividend = 8'd200; divisor = 8'd3; mask = 8'h05; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, mm_obs} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b vld=%b q=%0d r=%0d dz=%b mm=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, mm_obs);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_op("post_reset_200_7", 8'd200, 8'd7, 8'h00, 8'd28, 8'd4, 1'b0, 1'b0, LAT_RUN);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, rm;
        logic dz, mm;
        int lat, a0, a1;
        run_op(8'd150, 8'd11, 8'h00, q, rm, dz, mm, lat, a0);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b, want 1", in_ready);
        end
        run_op(8'd77, 8'd5, 8'h00, q, rm, dz, mm, lat, a1);
        n_cmp++;
        if (a1 - a0 !== W + 2) begin
            n_fail++;
            $display("FAIL b2b_interval: got %0d, want %0d", a1 - a0, W + 2);
        end
        n_cmp++;
        if (q !== 8'd15 || rm !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_result: got q=%0d r=%0d, want 15 2", q, rm);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        dividend = '0; divisor = '0; mask = '0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_all_ones_mask();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
